cmd_arb: RTL

Arbiter that shares the single cmd_proc command port between two requesters: the UART host path and the tour-replay sequencer. Latches the winning 16-bit command, presents it to cmd_proc with the cmd_rdy/clr_cmd_rdy handshake, and holds ownership until send_resp. Routes completion back to the owner and forms the UART response byte. Supervises each command with a watchdog timeout. Sits between UART_wrapper/tour sequencer and cmd_proc.

---
 rtl/cmd_pkg.sv | 26 ++
 rtl/cmd_wdog.sv | 33 +++
 rtl/cmd_arb.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// Shared types and constants for the cmd_proc command-port arbiter.
package cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_UART = 1'b0,
        OWN_TOUR = 1'b1
    } owner_t;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_TMO  = 8'hE1;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    function automatic logic [3:0] cmd_opcode(input logic [15:0] cmd_word);
        return cmd_word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/cmd_wdog.sv
// Saturating command watchdog: cleared while a command is issued, counts while
// busy, and flags expiry once the count reaches LIMIT-1.
module cmd_wdog #(
    parameter int LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] CNT_MAX = W'(LIMIT - 1);

    logic [W-1:0] cnt_r;

    assign expired = (cnt_r == CNT_MAX);

    // Counter register; holds at CNT_MAX instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && !expired) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/cmd_arb.sv
// Two-way round-robin arbiter for the cmd_proc command port (UART host vs
// tour sequencer) with completion routing and per-command watchdog.
module cmd_arb
    import cmd_pkg::*;
#(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd_uart,
    input  logic        rdy_uart,
    output logic        clr_uart,
    input  logic [15:0] cmd_tour,
    input  logic        rdy_tour,
    output logic        clr_tour,
    input  logic        tour_lock,
    output logic        tour_ack,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        resp_vld,
    output logic        tmo_err
);

    arb_state_t  state_r, state_nx;
    owner_t      owner_r, last_owner_r;
    logic [15:0] cmd_r;
    logic        cmd_rdy_r;
    logic [7:0]  resp_r;
    logic        resp_vld_r, tour_ack_r, tmo_err_r;

    logic        elig_uart_s, elig_tour_s;
    logic        grant_uart_s, grant_tour_s;
    logic        finish_s, tmo_s;
    logic        wdog_clr_s, wdog_en_s, wdog_exp_s;

    assign elig_uart_s = rdy_uart && !tour_lock;
    assign elig_tour_s = rdy_tour;
    assign wdog_clr_s  = (state_r == ISSUE);
    assign wdog_en_s   = (state_r == BUSY);

    cmd_wdog #(
        .LIMIT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wdog_clr_s),
        .en      (wdog_en_s),
        .expired (wdog_exp_s)
    );

    // Next-state, grant and completion decode.
    always_comb begin
        state_nx     = state_r;
        grant_uart_s = 1'b0;
        grant_tour_s = 1'b0;
        finish_s     = 1'b0;
        tmo_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (elig_uart_s && elig_tour_s) begin
                    // Tie goes to whichever source did not own the last command.
                    if (last_owner_r == OWN_TOUR) begin
                        grant_uart_s = 1'b1;
                    end else begin
                        grant_tour_s = 1'b1;
                    end
                    state_nx = ISSUE;
                end else if (elig_uart_s) begin
                    grant_uart_s = 1'b1;
                    state_nx     = ISSUE;
                end else if (elig_tour_s) begin
                    grant_tour_s = 1'b1;
                    state_nx     = ISSUE;
                end else begin
                    state_nx = IDLE;
                end
            end
            ISSUE: begin
                if (clr_cmd_rdy && send_resp) begin
                    finish_s = 1'b1;
                    state_nx = DONE;
                end else if (clr_cmd_rdy) begin
                    state_nx = BUSY;
                end else begin
                    state_nx = ISSUE;
                end
            end
            BUSY: begin
                if (send_resp) begin
                    finish_s = 1'b1;
                    state_nx = DONE;
                end else if (wdog_exp_s) begin
                    finish_s = 1'b1;
                    tmo_s    = 1'b1;
                    state_nx = DONE;
                end else begin
                    state_nx = BUSY;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, latched command, ownership and registered completion pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            owner_r      <= OWN_UART;
            last_owner_r <= OWN_TOUR;
            cmd_r        <= 16'h0000;
            cmd_rdy_r    <= 1'b0;
            resp_r       <= 8'h00;
            resp_vld_r   <= 1'b0;
            tour_ack_r   <= 1'b0;
            tmo_err_r    <= 1'b0;
        end else begin
            state_r <= state_nx;

            if (grant_uart_s) begin
                cmd_r   <= cmd_uart;
                owner_r <= OWN_UART;
            end else if (grant_tour_s) begin
                cmd_r   <= cmd_tour;
                owner_r <= OWN_TOUR;
            end else begin
                cmd_r   <= cmd_r;
                owner_r <= owner_r;
            end

            if (grant_uart_s || grant_tour_s) begin
                cmd_rdy_r <= 1'b1;
            end else if ((state_r == ISSUE) && clr_cmd_rdy) begin
                cmd_rdy_r <= 1'b0;
            end else begin
                cmd_rdy_r <= cmd_rdy_r;
            end

            resp_vld_r <= finish_s && (owner_r == OWN_UART);
            tour_ack_r <= finish_s && (owner_r == OWN_TOUR);
            tmo_err_r  <= tmo_s;

            if (finish_s && (owner_r == OWN_UART)) begin
                resp_r <= tmo_s ? RESP_TMO : RESP_DONE;
            end else begin
                resp_r <= resp_r;
            end

            if (state_r == DONE) begin
                last_owner_r <= owner_r;
            end else begin
                last_owner_r <= last_owner_r;
            end
        end
    end

    assign clr_uart = grant_uart_s;
    assign clr_tour = grant_tour_s;
    assign cmd      = cmd_r;
    assign cmd_rdy  = cmd_rdy_r;
    assign resp     = resp_r;
    assign resp_vld = resp_vld_r;
    assign tour_ack = tour_ack_r;
    assign tmo_err  = tmo_err_r;

endmodule
